// File: rtl/loader_pkg.sv
// Shared types and helpers for the boot-time instruction-memory loader.
package loader_pkg;

    localparam int LOADER_BYTE_W = 8;

    // Frame parser states; RUN and ERROR are terminal until load_req or reset.
    typedef enum logic [2:0] {
        ST_LEN_HI  = 3'd0,
        ST_LEN_LO  = 3'd1,
        ST_DATA_HI = 3'd2,
        ST_DATA_LO = 3'd3,
        ST_CHECK   = 3'd4,
        ST_RUN     = 3'd5,
        ST_ERROR   = 3'd6
    } loader_state_t;

    // Running frame checksum: plain 8-bit add, wrapping modulo 256.
    function automatic logic [LOADER_BYTE_W-1:0] loader_checksum(
        input logic [LOADER_BYTE_W-1:0] sum,
        input logic [LOADER_BYTE_W-1:0] data
    );
        return sum + data;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot loader: parses a length/words/checksum byte frame, writes the words
// into instruction memory and releases the CPU once the checksum matches.
module imem_loader
    import loader_pkg::*;
#(
    parameter int INSTR_WIDTH        = 16,
    parameter int ROM_REGISTER_COUNT = 1024,
    localparam int AW                = $clog2(ROM_REGISTER_COUNT),
    localparam int IW                = AW + 1
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     s_valid,
    input  logic [LOADER_BYTE_W-1:0] s_data,
    output logic                     s_ready,
    input  logic                     load_req,
    output logic                     wr_en,
    output logic [AW-1:0]            wr_addr,
    output logic [INSTR_WIDTH-1:0]   wr_data,
    output logic                     cpu_resetN,
    output logic                     done,
    output logic                     error
);

    localparam int LEN_W = 2 * LOADER_BYTE_W;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(ROM_REGISTER_COUNT);

    loader_state_t              state_r;
    logic [LOADER_BYTE_W-1:0]   sum_r;
    logic [LOADER_BYTE_W-1:0]   len_hi_r;
    logic [LOADER_BYTE_W-1:0]   hi_r;
    logic [IW-1:0]              len_r;
    logic [IW-1:0]              idx_r;
    logic                       wr_en_r;
    logic [AW-1:0]              wr_addr_r;
    logic [INSTR_WIDTH-1:0]     wr_data_r;
    logic                       cpu_resetn_r;
    logic                       done_r;
    logic                       error_r;

    logic                       ready_s;
    logic                       accept_s;
    logic [LEN_W-1:0]           len_s;
    logic [IW-1:0]              idx_next_s;
    logic [LOADER_BYTE_W-1:0]   sum_next_s;

    // Byte acceptance is a pure state decode; there is no input buffer.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CHECK: ready_s = 1'b1;
            default:                                               ready_s = 1'b0;
        endcase
    end

    assign accept_s   = s_valid && ready_s;
    assign len_s      = {len_hi_r, s_data};
    assign idx_next_s = idx_r + IW'(1);
    assign sum_next_s = loader_checksum(sum_r, s_data);

    // Frame FSM, word assembler, word counter, checksum and registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r      <= ST_LEN_HI;
            sum_r        <= 8'h00;
            len_hi_r     <= 8'h00;
            hi_r         <= 8'h00;
            len_r        <= '0;
            idx_r        <= '0;
            wr_en_r      <= 1'b0;
            wr_addr_r    <= '0;
            wr_data_r    <= '0;
            cpu_resetn_r <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            wr_en_r <= 1'b0;
            if (load_req) begin
                // Restart wins over a simultaneous byte, which is dropped.
                state_r      <= ST_LEN_HI;
                sum_r        <= 8'h00;
                idx_r        <= '0;
                cpu_resetn_r <= 1'b0;
                done_r       <= 1'b0;
                error_r      <= 1'b0;
            end else if (accept_s) begin
                case (state_r)
                    ST_LEN_HI: begin
                        len_hi_r <= s_data;
                        sum_r    <= sum_next_s;
                        state_r  <= ST_LEN_LO;
                    end
                    ST_LEN_LO: begin
                        sum_r <= sum_next_s;
                        if (len_s == 16'h0000) begin
                            state_r <= ST_CHECK;
                        end else if (len_s > MAX_LEN) begin
                            state_r <= ST_ERROR;
                            error_r <= 1'b1;
                        end else begin
                            len_r   <= len_s[IW-1:0];
                            state_r <= ST_DATA_HI;
                        end
                    end
                    ST_DATA_HI: begin
                        hi_r    <= s_data;
                        sum_r   <= sum_next_s;
                        state_r <= ST_DATA_LO;
                    end
                    ST_DATA_LO: begin
                        wr_en_r   <= 1'b1;
                        wr_addr_r <= idx_r[AW-1:0];
                        wr_data_r <= INSTR_WIDTH'({hi_r, s_data});
                        idx_r     <= idx_next_s;
                        sum_r     <= sum_next_s;
                        state_r   <= (idx_next_s == len_r) ? ST_CHECK : ST_DATA_HI;
                    end
                    ST_CHECK: begin
                        if (s_data == sum_r) begin
                            state_r      <= ST_RUN;
                            done_r       <= 1'b1;
                            cpu_resetn_r <= 1'b1;
                        end else begin
                            state_r <= ST_ERROR;
                            error_r <= 1'b1;
                        end
                    end
                    default: begin
                        // Unreachable/illegal encoding: fail safe, CPU stays in reset.
                        state_r      <= ST_ERROR;
                        error_r      <= 1'b1;
                        done_r       <= 1'b0;
                        cpu_resetn_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign s_ready    = ready_s;
    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign cpu_resetN = cpu_resetn_r;
    assign done       = done_r;
    assign error      = error_r;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected memory writes are queued by the
// stimulus and retired by a monitor; status outputs are checked directly.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready;
    logic        load_req = 1'b0;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cpu_resetN;
    logic        done;
    logic        error;

    typedef struct packed {
        logic [9:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    imem_loader #(.INSTR_WIDTH(16), .ROM_REGISTER_COUNT(1024)) dut (
        .clk(clk), .resetN(resetN), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .load_req(load_req), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .cpu_resetN(cpu_resetN),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (resetN === 1'b1 && wr_en !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write addr=%0h data=%0h required=none", wr_addr, wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_en", {31'd0, wr_en}, 32'd1);
                chk("wr_addr", {22'd0, wr_addr}, {22'd0, e.addr});
                chk("wr_data", {16'd0, wr_data}, {16'd0, e.data});
            end
        end
    end

    task automatic push_wr(input logic [9:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Drive one byte and return after the edge on which it is accepted.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        int cnt;
        if (gaps) begin
            n = $urandom_range(0, 2);
            repeat (n) begin
                @(negedge clk);
                s_valid = 1'b0;
            end
        end
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        cnt = 0;
        while (s_ready !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (s_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout byte=%0h actual=not_ready required=ready", b);
        end
        @(posedge clk);
    endtask

    task automatic send_bytes(input logic [7:0] bytes[$], input bit gaps);
        foreach (bytes[i]) send_byte(bytes[i], gaps);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic pulse_load();
        @(negedge clk);
        load_req = 1'b1;
        s_valid  = 1'b0;
        @(negedge clk);
        load_req = 1'b0;
        chk("restart_done", {31'd0, done}, 32'd0);
        chk("restart_error", {31'd0, error}, 32'd0);
        chk("restart_cpu_resetN", {31'd0, cpu_resetN}, 32'd0);
        chk("restart_s_ready", {31'd0, s_ready}, 32'd1);
    endtask

    task automatic chk_status(input string tag, input logic d, input logic e,
                              input logic c, input logic r);
        chk({tag, "_done"}, {31'd0, done}, {31'd0, d});
        chk({tag, "_error"}, {31'd0, error}, {31'd0, e});
        chk({tag, "_cpu_resetN"}, {31'd0, cpu_resetN}, {31'd0, c});
        chk({tag, "_s_ready"}, {31'd0, s_ready}, {31'd0, r});
        chk({tag, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd1);
        chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        chk({tag, "_wr_addr"}, {22'd0, wr_addr}, 32'd0);
        chk({tag, "_wr_data"}, {16'd0, wr_data}, 32'd0);
        chk({tag, "_cpu_resetN"}, {31'd0, cpu_resetN}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fr[$];
        logic [7:0] sum;
        logic [15:0] w;

        // Reset state.
        #1 resetN = 1'b0;
        #2 chk_reset_values("reset");
        repeat (2) @(negedge clk);
        resetN = 1'b1;

        // Nominal load; done must still be low just before the CHK edge.
        push_wr(10'd0, 16'h1234);
        push_wr(10'd1, 16'hABCD);
        fr = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        send_bytes(fr, 1'b0);
        chk("pre_chk_done", {31'd0, done}, 32'd0);
        chk("pre_chk_cpu_resetN", {31'd0, cpu_resetN}, 32'd0);
        send_byte(8'hC0, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        chk_status("nominal", 1'b1, 1'b0, 1'b1, 1'b0);

        // Bad checksum.
        pulse_load();
        push_wr(10'd0, 16'h1234);
        push_wr(10'd1, 16'hABCD);
        fr = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1};
        send_bytes(fr, 1'b0);
        chk_status("badchk", 1'b0, 1'b1, 1'b0, 1'b0);

        // Oversize length: 0x0401 = 1025 words.
        pulse_load();
        fr = '{8'h04, 8'h01};
        send_bytes(fr, 1'b0);
        chk_status("oversize", 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 8'h00;
        repeat (3) @(negedge clk);
        s_valid = 1'b0;
        chk_status("oversize_hold", 1'b0, 1'b1, 1'b0, 1'b0);

        // Empty image.
        pulse_load();
        fr = '{8'h00, 8'h00, 8'h00};
        send_bytes(fr, 1'b0);
        chk_status("empty", 1'b1, 1'b0, 1'b1, 1'b0);

        // Backpressure and restart; the restart collides with the CD byte.
        pulse_load();
        push_wr(10'd0, 16'h1234);
        fr = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
        foreach (fr[i]) send_byte(fr[i], 1'b1);
        @(negedge clk);
        s_valid  = 1'b1;
        s_data   = 8'hCD;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        s_valid  = 1'b0;
        @(negedge clk);
        chk_status("restart", 1'b0, 1'b0, 1'b0, 1'b1);
        push_wr(10'd0, 16'h1234);
        push_wr(10'd1, 16'hABCD);
        fr = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
        foreach (fr[i]) send_byte(fr[i], 1'b1);
        @(negedge clk);
        s_valid = 1'b0;
        chk_status("resend", 1'b1, 1'b0, 1'b1, 1'b0);

        // Async reset in DATA_LO, then a fresh frame.
        pulse_load();
        push_wr(10'd0, 16'h1234);
        fr = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
        foreach (fr[i]) send_byte(fr[i], 1'b0);
        #2 resetN = 1'b0;
        #1 chk_reset_values("async_reset");
        chk("async_reset_queue_empty", exp_q.size(), 32'd0);
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        push_wr(10'd0, 16'h1234);
        push_wr(10'd1, 16'hABCD);
        fr = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
        send_bytes(fr, 1'b0);
        chk_status("post_reset", 1'b1, 1'b0, 1'b1, 1'b0);

        // Full-depth image: 1024 words, last word lands at address 1023.
        pulse_load();
        fr = '{8'h04, 8'h00};
        sum = 8'h04;
        for (int i = 0; i < 1024; i++) begin
            w = 16'(i * 7) ^ 16'h5A00;
            push_wr(10'(i), w);
            fr.push_back(w[15:8]);
            fr.push_back(w[7:0]);
            sum = sum + w[15:8] + w[7:0];
        end
        fr.push_back(sum);
        send_bytes(fr, 1'b0);
        chk_status("full_depth", 1'b1, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
